ab_sweep_checker: RTL

//  Stimulus/response end of the 2-input registered-logic interface (a, b -> r0, r1, r2).
//  - On start, drives every {a,b} combination in a fixed sweep for ROUNDS rounds.
//  - Captures r0/r1/r2 after LAT cycles and compares them with the reference function
//    (r0=a&b, r1=a&b, r2=~(a^b)).
//  - Reports a mismatch count and a pass flag.

---
 rtl/ab_chk_pkg.sv | 25 ++
 rtl/ab_sweep_checker_if.sv | 12 +
 rtl/ab_exp_delay.sv | 34 +++
 rtl/ab_sweep_checker.sv | 137 +++++++++++++
 4 files changed

// File: rtl/ab_chk_pkg.sv
// Shared types and the reference response for the a/b sweep checker.
// Both the top and the expectation delay line import this package.
package ab_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int VEC_PER_ROUND = 4;

  typedef struct packed {
    logic       valid;
    logic [1:0] ab;
    logic [2:0] exp;
  } dly_entry_t;

  // Expected {r0, r1, r2} for a given stimulus pair.
  function automatic logic [2:0] exp_resp(input logic a, input logic b);
    return {a & b, a & b, ~(a ^ b)};
  endfunction

endpackage

// File: rtl/ab_sweep_checker_if.sv
// Stimulus/response bus between the sweep checker and the registered-logic block.
// The master drives a/b and samples r0..r2; the slave is the block under check.
interface ab_sweep_checker_if;
  logic a;
  logic b;
  logic r0;
  logic r1;
  logic r2;

  modport master (output a, output b, input r0, input r1, input r2);
  modport slave  (input a, input b, output r0, output r1, output r2);
endinterface

// File: rtl/ab_exp_delay.sv
// LAT-deep shift register carrying the expected response of each driven vector
// so it lines up with the block's registered answer.
module ab_exp_delay
  import ab_chk_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  dly_entry_t i_entry,
  output dly_entry_t o_head,
  output logic       o_pending
);

  dly_entry_t r_stage [LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_entry;
      for (int i = 1; i < LAT; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_head = r_stage[LAT-1];

  // Valid entries that will still be in flight after the head is consumed.
  always_comb begin
    o_pending = 1'b0;
    for (int i = 0; i < LAT - 1; i++) o_pending = o_pending | r_stage[i].valid;
  end

endmodule

// File: rtl/ab_sweep_checker.sv
// Drives every {a,b} pair for ROUNDS sweeps, checks r0..r2 LAT cycles later,
// and reports a saturating mismatch count, the first failing pair and a pass flag.
module ab_sweep_checker
  import ab_chk_pkg::*;
#(
  parameter int ROUNDS = 4,
  parameter int LAT    = 1,
  parameter int CNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  ab_sweep_checker_if.master        bus,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [CNT_W-1:0]          err_cnt,
  output logic [1:0]                err_ab,
  output state_t                    dbg_state
);

  // Handshake: start is a one-cycle request honoured only in IDLE; each accepted
  // start yields exactly one done pulse, with pass/err_cnt/err_ab valid from then on.

  localparam int RND_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  state_t             r_state;
  state_t             w_next;
  logic [1:0]         r_vec;
  logic [RND_W-1:0]   r_round;
  logic               r_a;
  logic               r_b;
  logic               r_ab_vld;
  logic               r_busy;
  logic               r_done;
  logic               r_pass;
  logic [CNT_W-1:0]   r_err_cnt;
  logic [CNT_W-1:0]   w_err_next;
  logic [1:0]         r_err_ab;
  logic               w_last;
  logic               w_pending;
  logic               w_mismatch;
  dly_entry_t         w_push;
  dly_entry_t         w_head;

  assign w_last = (r_vec == 2'd3) && (r_round == RND_W'(ROUNDS - 1));

  // The entry travels with the registered a/b so that LAT stages align it with r0..r2.
  always_comb begin
    w_push       = '0;
    w_push.valid = r_ab_vld;
    w_push.ab    = {r_a, r_b};
    w_push.exp   = exp_resp(r_a, r_b);
  end

  ab_exp_delay #(.LAT(LAT)) u_delay (
    .clk       (clk),
    .rst       (rst),
    .i_entry   (w_push),
    .o_head    (w_head),
    .o_pending (w_pending)
  );

  assign w_mismatch = w_head.valid && ({bus.r0, bus.r1, bus.r2} != w_head.exp);

  always_comb begin
    w_err_next = r_err_cnt;
    if (w_mismatch && (r_err_cnt != {CNT_W{1'b1}})) w_err_next = r_err_cnt + CNT_W'(1);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = DRIVE;
      DRIVE:   if (w_last) w_next = DRAIN;
      DRAIN:   if (!r_ab_vld && !w_pending) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vec     <= '0;
      r_round   <= '0;
      r_a       <= 1'b0;
      r_b       <= 1'b0;
      r_ab_vld  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_err_cnt <= '0;
      r_err_ab  <= '0;
    end else begin
      r_busy       <= (w_next != IDLE);
      r_done       <= (w_next == DONE);
      {r_a, r_b}   <= (r_state == DRIVE) ? r_vec : 2'b00;
      r_ab_vld     <= (r_state == DRIVE);
      if ((r_state == IDLE) && start) begin
        r_vec     <= '0;
        r_round   <= '0;
        r_pass    <= 1'b0;
        r_err_cnt <= '0;
        r_err_ab  <= '0;
      end else begin
        if (r_state == DRIVE) begin
          r_vec <= r_vec + 2'd1;
          if (r_vec == 2'd3) r_round <= r_round + RND_W'(1);
        end
        r_err_cnt <= w_err_next;
        if (w_mismatch && (r_err_cnt == '0)) r_err_ab <= w_head.ab;
        // pass uses the post-compare count because the last compare lands on this edge.
        if (w_next == DONE) r_pass <= (w_err_next == '0);
      end
    end
  end

  assign bus.a     = r_a;
  assign bus.b     = r_b;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_cnt   = r_err_cnt;
  assign err_ab    = r_err_ab;
  assign dbg_state = r_state;

  a_done_then_idle: assert property (@(posedge clk) disable iff (rst) done |=> !busy);
  a_busy_not_idle:  assert property (@(posedge clk) disable iff (rst) busy |-> (r_state != IDLE));
  a_cnt_monotonic:  assert property (@(posedge clk) disable iff (rst) busy |=> (err_cnt >= $past(err_cnt)));
  a_pass_on_done:   assert property (@(posedge clk) disable iff (rst) done |-> (pass == (err_cnt == '0)));

endmodule
